regfile_bypass: RTL
===================

# regfile_bypass

Parametrised integer register file for the core pipeline. It has NREAD registered read ports captured in the decode stage and one write-back port, and forwards same-cycle write-back to the read ports. A pending-write scoreboard raises a hazard flag while a source register awaits its producer. It supersedes the fixed 32x32, 2-read register file and gives decode a single stall source.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- NREAD, 2, number of read ports, 1 to 4
- AW, $clog2(NREGS), register address width (derived, not overridden)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and issues

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- d_en  in  1  decode-stage capture enable for the read ports
- rs_addr  in  NREAD*AW  packed source addresses; port k occupies bits [k*AW +: AW]
- rs_data  out  NREAD*XLEN  registered read data, packed the same way
- hazard  out  1  combinational; 1 when any current rs_addr is pending and is not being resolved this cycle
- iss_valid  in  1  an instruction with destination iss_rd is issuing
- iss_rd  in  AW  destination of the issuing instruction
- wb_we  in  1  write-back enable
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back data
- flush  in  1  pipeline flush; discards all pending writes

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit `busy` vector.
- Write: on each edge with wb_we=1, x[wb_rd] <= wb_data. When ZERO_REG=1 and wb_rd=0, the write is dropped.
- Read capture happens on each edge with d_en=1. For each port k:
  - If wb_we=1, wb_rd=rs_addr[k], and the write is not dropped: rs_data[k] <= wb_data (bypass).
  - Otherwise: rs_data[k] <= x[rs_addr[k]].
  - When ZERO_REG=1 and rs_addr[k]=0, rs_data[k] <= 0 regardless of wb.
- With d_en=0, rs_data holds its value.
- Scoreboard update, evaluated in priority order on each edge:
  - flush=1: busy <= 0; iss_valid is ignored that cycle.
  - Else: wb_we clears busy[wb_rd], then iss_valid sets busy[iss_rd]. When iss_rd=wb_rd, busy ends at 1 because the new producer wins.
  - With ZERO_REG=1, busy[0] stays 0.
- Hazard: hazard = OR over k of (busy[rs_addr[k]] AND NOT(wb_we AND wb_rd=rs_addr[k] AND write not dropped)). Decode stalls (d_en=0 upstream) while hazard=1.
- Widths: no arithmetic. Addresses at or above NREGS cannot occur because NREGS is a power of two.

## Timing
- Reset (async assert, sync deassert in the clock domain):
  - All x[i]=0, busy=0, rs_data=0, so hazard=0.
  - Reset mid-operation discards pending writes and in-flight bypass.
- Read latency is 1 cycle: address presented with d_en at edge N gives data valid after edge N.
- Write-to-read is 0 extra cycles: a write-back at edge N is visible to a capture at edge N via the bypass.
- Issue-to-hazard is 1 cycle: busy is set after the issue edge, and hazard reflects it in the following cycle.
- Write-back clears the hazard in the same cycle through the bypass term, and busy clears after that edge.
- The hazard path is combinational from rs_addr, wb_*, and busy. There is no combinational path from iss_* or flush to any output.

## Structure
- Package regfile_pkg:
  - Default XLEN and NREGS constants.
  - The addr_t / data_t typedefs.
  - A function `pack_idx(k, w)` for slicing packed buses.
- Sub-module regfile_scoreboard:
  - Contents: the busy vector, flush/issue/wb priority, and the NREAD-way hazard reduction.
  - Parameters: NREGS, NREAD, ZERO_REG.
  - The top level holds the array, the write port, and the read/bypass muxes.

## Test plan
- Reset then read: assert rst, release, d_en=1 with rs_addr={5,3} -> rs_data={0,0}, hazard=0.
- Write then read: wb_we=1, wb_rd=7, wb_data=0xDEADBEEF; next cycle rs_addr[0]=7, d_en=1 -> rs_data[0]=0xDEADBEEF after the edge.
- Bypass and zero register:
  - Same edge wb_rd=9 with data 0x1234 while rs_addr[1]=9, d_en=1 -> rs_data[1]=0x1234.
  - wb_rd=0 with data 0xFFFF_FFFF -> a later read of reg 0 returns 0.
- Scoreboard:
  - iss_valid, iss_rd=4 -> next cycle rs_addr[0]=4 gives hazard=1.
  - Then wb_we, wb_rd=4 -> hazard=0 in that cycle and captured data equals wb_data.
- Simultaneous events:
  - iss_rd=wb_rd=6 on the same edge -> busy[6]=1 after the edge.
  - flush together with iss_rd=2 -> busy all 0 and hazard=0 for rs_addr=2.
- Parameter sweep:
  - NREAD=4, NREGS=16, XLEN=64: random issue/wb/flush traffic against a reference model checks rs_data and hazard every cycle.
  - Async rst asserted mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults, types and bus-slicing helper for the register file.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int c_XLEN_DEFAULT  = 32;
    localparam int c_NREGS_DEFAULT = 32;

    typedef logic [$clog2(c_NREGS_DEFAULT)-1:0] addr_t;
    typedef logic [c_XLEN_DEFAULT-1:0]          data_t;

    // Base bit of lane k in a packed bus of w-bit lanes.
    function automatic int pack_idx(input int k, input int w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Pending-write busy vector and NREAD-way read hazard detection.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = c_NREGS_DEFAULT,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREAD*AW-1:0] rs_addr,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_rd,
    input  logic                flush,
    output logic                hazard
);

    logic [NREGS-1:0] r_busy;
    logic [NREAD-1:0] w_hit;
    logic             w_wb_live;

    assign w_wb_live = wb_we && !((ZERO_REG != 0) && (wb_rd == '0));

    // Issue is applied after write-back so a new producer of the same register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            if (wb_we) begin
                r_busy[wb_rd] <= 1'b0;
            end
            if (iss_valid) begin
                r_busy[iss_rd] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                r_busy[0] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        logic [AW-1:0] w_addr;
        assign w_addr   = rs_addr[pack_idx(k, AW) +: AW];
        assign w_hit[k] = r_busy[w_addr] && !(w_wb_live && (wb_rd == w_addr));
    end

    assign hazard = |w_hit;

endmodule
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass
// Brief    : Parametrised register file with registered read ports, same-cycle
//            write-back bypass and a pending-write hazard scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int XLEN     = c_XLEN_DEFAULT,
    parameter int NREGS    = c_NREGS_DEFAULT,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_en,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic                  hazard,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush
);

    logic [XLEN-1:0] r_regs    [NREGS];
    logic [XLEN-1:0] r_rd      [NREAD];
    logic [XLEN-1:0] w_rd_next [NREAD];
    logic            w_wb_live;

    assign w_wb_live = wb_we && !((ZERO_REG != 0) && (wb_rd == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_live) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rs_addr[pack_idx(k, AW) +: AW];

        // Zero register beats the bypass, which beats the array.
        always_comb begin
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_rd_next[k] = '0;
            end else if (w_wb_live && (wb_rd == w_addr)) begin
                w_rd_next[k] = wb_data;
            end else begin
                w_rd_next[k] = r_regs[w_addr];
            end
        end

        assign rs_data[pack_idx(k, XLEN) +: XLEN] = r_rd[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREAD; k++) begin
                r_rd[k] <= '0;
            end
        end else if (d_en) begin
            for (int k = 0; k < NREAD; k++) begin
                r_rd[k] <= w_rd_next[k];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .hazard    (hazard)
    );

endmodule
`default_nettype wire
